i2s_rx_frame: RTL and testbench

I2S_RX_FRAME -- requirements
Module: i2s_rx_frame

---
 rtl/i2s_rx_frame.sv | 202 ++++++++++++++++++++
 tb/tb_i2s_rx_frame.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_frame.sv
// I2S receiver: deserialises left/right slots and queues {left, right} frames in a small FIFO.
// Define I2S_RX_PEAK_EN to build the per-channel magnitude peak hold; otherwise the peak ports read 0.
module i2s_rx_frame #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic             sck,
    input  logic             reset,
    input  logic             ws,
    input  logic             sd,
    input  logic             frame_ready,
    input  logic             ovf_clr,
    input  logic             peak_clr,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             frame_valid,
    output logic             sync_ok,
    output logic             overflow,
    output logic [WIDTH-1:0] peak_left,
    output logic [WIDTH-1:0] peak_right
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [CW-1:0] BIT_END  = CW'(WIDTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    genvar gi;

    logic             ws_d_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] word_next;
    logic             sync_reg;
    logic             slot_edge;
    logic             take_bit;
    logic             commit;

    logic [WIDTH-1:0] left_hold_reg;
    logic             left_valid_reg;
    logic             push_pend_reg;
    logic [WIDTH-1:0] push_l_reg;
    logic [WIDTH-1:0] push_r_reg;

    logic [WIDTH-1:0] mem_l [DEPTH];
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             ovf_reg;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;

    assign slot_edge = (ws != ws_d_reg);
    assign take_bit  = (bit_cnt_reg < BIT_END);
    // Words are only trusted once a 1->0 edge has marked the start of a left slot.
    assign commit    = slot_edge && sync_reg;

    // word_next is the shift register with the current sample dropped into its MSB-first slot;
    // once WIDTH bits are in, the counter stops matching and later bits fall away.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign word_next[gi] = (bit_cnt_reg == CW'(WIDTH - 1 - gi)) ? sd : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            ws_d_reg    <= 1'b0;
            bit_cnt_reg <= BIT_END;
            shift_reg   <= '0;
            sync_reg    <= 1'b0;
        end else begin
            ws_d_reg <= ws;
            if (slot_edge) begin
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
                if (ws_d_reg && !ws) begin
                    sync_reg <= 1'b1;
                end
            end else begin
                shift_reg <= word_next;
                if (take_bit) begin
                    bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                end
            end
        end
    end

    // At a slot edge ws_d still holds the ending slot's channel.
    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            left_hold_reg  <= '0;
            left_valid_reg <= 1'b0;
            push_pend_reg  <= 1'b0;
            push_l_reg     <= '0;
            push_r_reg     <= '0;
        end else begin
            push_pend_reg <= 1'b0;
            if (commit) begin
                if (!ws_d_reg) begin
                    left_hold_reg  <= word_next;
                    left_valid_reg <= 1'b1;
                end else if (left_valid_reg) begin
                    push_pend_reg  <= 1'b1;
                    push_l_reg     <= left_hold_reg;
                    push_r_reg     <= word_next;
                    left_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign frame_valid = (count_reg != '0);
    assign pop         = frame_valid && frame_ready;
    assign full        = (count_reg == CNT_FULL);
    assign push        = push_pend_reg && (!full || pop);
    assign drop        = push_pend_reg && full && !pop;

    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge sck) begin
        if (push) begin
            mem_l[wr_ptr_reg] <= push_l_reg;
            mem_r[wr_ptr_reg] <= push_r_reg;
        end
    end

    assign left_data  = frame_valid ? mem_l[rd_ptr_reg] : '0;
    assign right_data = frame_valid ? mem_r[rd_ptr_reg] : '0;
    assign sync_ok    = sync_reg;
    assign overflow   = ovf_reg;

`ifdef I2S_RX_PEAK_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement magnitude; the most negative code saturates to the largest positive one.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] s);
        if (!s[WIDTH-1]) begin
            return s;
        end
        if (s == MOST_NEG) begin
            return ~MOST_NEG;
        end
        return -s;
    endfunction

    generate
        for (gi = 0; gi < 2; gi++) begin : g_peak
            logic [WIDTH-1:0] peak_reg;
            logic [WIDTH-1:0] mag;
            assign mag = magnitude((gi == 0) ? push_l_reg : push_r_reg);
            always_ff @(posedge sck or negedge reset) begin
                if (!reset) begin
                    peak_reg <= '0;
                end else if (peak_clr) begin
                    peak_reg <= '0;
                end else if (push && (mag > peak_reg)) begin
                    peak_reg <= mag;
                end
            end
        end
    endgenerate

    assign peak_left  = g_peak[0].peak_reg;
    assign peak_right = g_peak[1].peak_reg;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_left       = '0;
    assign peak_right      = '0;
`endif

endmodule

// File: tb/tb_i2s_rx_frame.sv
// Directed bench for i2s_rx_frame (WIDTH=24, DEPTH=2): table of frames plus hand-written
// overflow, late-start and mid-slot reset sequences.
module tb_i2s_rx_frame;
    localparam int W = 24;
`ifdef I2S_RX_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic         sck = 1'b0;
    logic         rst_n;
    logic         ws;
    logic         sd;
    logic         frame_ready;
    logic         ovf_clr;
    logic         peak_clr;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         frame_valid;
    logic         sync_ok;
    logic         overflow;
    logic [W-1:0] peak_left;
    logic [W-1:0] peak_right;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic carry    = 1'b0;

    i2s_rx_frame #(.WIDTH(W), .DEPTH(2)) dut (
        .sck         (sck),
        .reset       (rst_n),
        .ws          (ws),
        .sd          (sd),
        .frame_ready (frame_ready),
        .ovf_clr     (ovf_clr),
        .peak_clr    (peak_clr),
        .left_data   (left_data),
        .right_data  (right_data),
        .frame_valid (frame_valid),
        .sync_ok     (sync_ok),
        .overflow    (overflow),
        .peak_left   (peak_left),
        .peak_right  (peak_right)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           n;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_pl;
        logic [W-1:0] exp_pr;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slot bit j of a word, MSB first; bits past WIDTH are padded with ones.
    function automatic logic bitof(input logic [W-1:0] w, input int j);
        if (j >= W) return 1'b1;
        return w[W-1-j];
    endfunction

    task automatic drive(input logic ch, input logic b);
        @(negedge sck);
        ws = ch;
        sd = b;
    endtask

    task automatic sample();
        @(posedge sck);
        #1;
    endtask

    // Bits [from,to) of an n-bit slot; slot bit 0 carries the previous slot's LSB (I2S delay).
    task automatic send(input logic ch, input logic [W-1:0] w, input int n, input int from, input int to);
        for (int i = from; i < to; i++) begin
            drive(ch, (i == 0) ? carry : bitof(w, i - 1));
        end
        if (to == n) carry = bitof(w, n - 1);
    endtask

    task automatic slot(input logic ch, input logic [W-1:0] w, input int n);
        send(ch, w, n, 0, n);
    endtask

    localparam logic [W-1:0] F1L = 24'h0A0001, F1R = 24'h0B0001;
    localparam logic [W-1:0] F2L = 24'h0A0002, F2R = 24'h0B0002;
    localparam logic [W-1:0] F3L = 24'h0A0003, F3R = 24'h0B0003;

    initial begin
        logic [W-1:0] nl;
        int           nn;
        logic         bad;

        vecs[0] = '{24'h000010, 24'hFFFFFF, 32, 24'h000010, 24'hFFFFFF, 24'h000010, 24'h000001};
        vecs[1] = '{24'hFFFF00, 24'h000005, 32, 24'hFFFF00, 24'h000005, 24'h000100, 24'h000005};
        vecs[2] = '{24'h800000, 24'h000002, 32, 24'h800000, 24'h000002, 24'h7FFFFF, 24'h000005};
        vecs[3] = '{24'h123456, 24'hABCDEF, 32, 24'h123456, 24'hABCDEF, 24'h7FFFFF, 24'h543211};
        vecs[4] = '{24'hBEEF00, 24'h123400, 16, 24'hBEEF00, 24'h123400, 24'h7FFFFF, 24'h543211};

        rst_n = 1'b0; ws = 1'b0; sd = 1'b0;
        frame_ready = 1'b1; ovf_clr = 1'b0; peak_clr = 1'b0;
        repeat (3) sample();
        chk("reset frame_valid", frame_valid, 0);
        chk("reset sync_ok", sync_ok, 0);
        chk("reset overflow", overflow, 0);
        chk("reset left_data", left_data, 0);
        chk("reset peak_left", peak_left, 0);
        @(negedge sck);
        rst_n = 1'b1;

        // Junk right slot, then the 1->0 edge that acquires sync.
        slot(1'b1, 24'h0, 32);
        send(1'b0, vecs[0].l, vecs[0].n, 0, 1);
        sample();
        chk("sync at first 1->0", sync_ok, 1);
        send(1'b0, vecs[0].l, vecs[0].n, 1, 3);

        for (int v = 0; v < 5; v++) begin
            send(1'b0, vecs[v].l, vecs[v].n, 3, vecs[v].n);
            slot(1'b1, vecs[v].r, vecs[v].n);
            nl = (v < 4) ? vecs[v+1].l : F1L;
            nn = (v < 4) ? vecs[v+1].n : 32;
            send(1'b0, nl, nn, 0, 1);
            sample();
            chk($sformatf("v%0d valid at slot end", v), frame_valid, 0);
            chk($sformatf("v%0d left zero when empty", v), left_data, 0);
            send(1'b0, nl, nn, 1, 2);
            sample();
            $display("frame %0d: valid=%0b left=%h right=%h peak=%h/%h", v, frame_valid,
                     left_data, right_data, peak_left, peak_right);
            chk($sformatf("v%0d valid one sck later", v), frame_valid, 1);
            chk($sformatf("v%0d left_data", v), left_data, vecs[v].exp_l);
            chk($sformatf("v%0d right_data", v), right_data, vecs[v].exp_r);
            chk($sformatf("v%0d peak_left", v), peak_left, PEAK_EN ? vecs[v].exp_pl : '0);
            chk($sformatf("v%0d peak_right", v), peak_right, PEAK_EN ? vecs[v].exp_pr : '0);
            send(1'b0, nl, nn, 2, 3);
            sample();
            chk($sformatf("v%0d popped", v), frame_valid, 0);
        end

        // peak_clr
        peak_clr = 1'b1;
        send(1'b0, F1L, 32, 3, 4);
        sample();
        peak_clr = 1'b0;
        chk("peak_clr left", peak_left, 0);
        chk("peak_clr right", peak_right, 0);

        // Three frames against a stalled consumer: third dropped, clear coinciding with drop loses.
        frame_ready = 1'b0;
        send(1'b0, F1L, 32, 4, 32);
        slot(1'b1, F1R, 32);
        slot(1'b0, F2L, 32);
        slot(1'b1, F2R, 32);
        slot(1'b0, F3L, 32);
        slot(1'b1, F3R, 32);
        send(1'b0, 24'h0, 32, 0, 1);
        sample();
        chk("ovf before drop", overflow, 0);
        ovf_clr = 1'b1;
        send(1'b0, 24'h0, 32, 1, 2);
        sample();
        ovf_clr = 1'b0;
        $display("overflow frame: valid=%0b left=%h right=%h ovf=%0b", frame_valid, left_data,
                 right_data, overflow);
        chk("ovf set despite clr", overflow, 1);
        chk("head F1 left", left_data, F1L);
        chk("head F1 right", right_data, F1R);
        repeat (4) sample();
        chk("ovf sticky", overflow, 1);
        chk("head stable", left_data, F1L);
        ovf_clr = 1'b1;
        sample();
        ovf_clr = 1'b0;
        chk("ovf cleared", overflow, 0);
        frame_ready = 1'b1;
        sample();
        chk("head F2 left", left_data, F2L);
        chk("head F2 right", right_data, F2R);
        sample();
        chk("fifo drained", frame_valid, 0);

        // Reset, then a stream that resumes in the middle of a right slot.
        rst_n = 1'b0; ws = 1'b1; sd = 1'b0;
        repeat (2) sample();
        rst_n = 1'b1;
        send(1'b1, 24'h5A5A5A, 32, 5, 32);
        chk("no sync mid-right", sync_ok, 0);
        chk("no frame mid-right", frame_valid, 0);
        send(1'b0, 24'h111111, 32, 0, 1);
        sample();
        chk("sync rises at 1->0", sync_ok, 1);
        chk("partial right discarded", frame_valid, 0);
        send(1'b0, 24'h111111, 32, 1, 32);
        slot(1'b1, 24'h222222, 32);
        send(1'b0, 24'h333333, 32, 0, 1);
        sample();
        chk("late-start valid at slot end", frame_valid, 0);
        send(1'b0, 24'h333333, 32, 1, 2);
        sample();
        frame_ready = 1'b0;
        $display("late-start frame: valid=%0b left=%h right=%h", frame_valid, left_data, right_data);
        chk("late-start valid", frame_valid, 1);
        chk("late-start left", left_data, 24'h111111);
        chk("late-start right", right_data, 24'h222222);

        // Reset mid-slot with that frame still pending.
        send(1'b0, 24'h333333, 32, 2, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset valid", frame_valid, 0);
        chk("async reset left", left_data, 0);
        chk("async reset right", right_data, 0);
        chk("async reset sync", sync_ok, 0);
        chk("async reset peak_right", peak_right, 0);
        repeat (2) sample();
        @(negedge sck);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            sample();
            if (frame_valid !== 1'b0) bad = 1'b1;
        end
        chk("no stale frame", bad, 0);
        slot(1'b1, 24'h444444, 32);
        chk("resync needed", sync_ok, 0);
        send(1'b0, 24'h555555, 32, 0, 1);
        sample();
        chk("resync at 1->0", sync_ok, 1);
        bad = 1'b0;
        for (int i = 1; i < 32; i++) begin
            send(1'b0, 24'h555555, 32, i, i + 1);
            if (frame_valid !== 1'b0) bad = 1'b1;
        end
        chk("no frame after resync", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
